updown_counter_param: RTL
=========================

# updown_counter_param

Parametrised up/down counter: the next generation of the team's 4-bit up/down counter. Adds configurable width, step and count range, plus count enable, synchronous load, and wrap or saturate behaviour at the range limits. Provides terminal-count flags, a boundary event pulse and a sticky overflow flag. Used as a general event, index or timeout counter inside larger datapaths and control FSMs.

## Interface
- WIDTH, 4, counter width in bits (2..32)
- MIN_VAL, 0, lowest count value; must satisfy MIN_VAL <= MAX_VAL
- MAX_VAL, 2**WIDTH-1, highest count value; must be < 2**WIDTH
- STEP, 1, increment/decrement amount; must satisfy 1 <= STEP <= MAX_VAL-MIN_VAL+1
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable
- chnge  in  1  direction: 1 = count up, 0 = count down
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- sat_mode  in  1  1 = saturate at the limits, 0 = wrap (see Configuration)
- clr_ovf  in  1  clears the sticky overflow flag
- out  out  WIDTH  current count
- at_max  out  1  combinational: out == MAX_VAL
- at_min  out  1  combinational: out == MIN_VAL
- wrap  out  1  registered one-cycle pulse on a boundary event
- ovf  out  1  sticky boundary-event flag

## Operation
- Reset (reset = 0, asynchronous) forces out = MIN_VAL, wrap = 0, ovf = 0. It holds while reset is low and overrides all other inputs.
- Priority per edge: load, then en, then hold.
- Load:
  - out <= load_val clamped to [MIN_VAL, MAX_VAL].
  - wrap <= 0.
  - A clamped load is not a boundary event.
- Count arithmetic uses WIDTH+1 bits, so there is no silent modular overflow.
- Up (en = 1, chnge = 1):
  - If out + STEP <= MAX_VAL: out <= out + STEP.
  - Otherwise a boundary event occurs: wrap mode gives out <= MIN_VAL; saturate mode gives out <= MAX_VAL.
- Down (en = 1, chnge = 0):
  - If out - STEP >= MIN_VAL: out <= out - STEP.
  - Otherwise a boundary event occurs: wrap mode gives out <= MAX_VAL; saturate mode gives out <= MIN_VAL.
- Saturate mode with out already at the limit, count toward the limit: out holds, and it still counts as a boundary event.
- Wrap lands exactly on the opposite limit; there is no remainder carry-over.
- wrap = 1 for exactly the cycle following each boundary event edge, otherwise 0. Back-to-back events keep wrap high.
- ovf:
  - Set on any boundary event.
  - Cleared by clr_ovf.
  - If set and clear occur on the same edge, set wins (ovf = 1).
- en = 0 with load = 0: out holds, wrap <= 0.
- sat_mode and chnge are sampled only on edges where en = 1 and load = 0. Changing them while counting is legal.

## Timing
- Latency: one CLK from en/load/clr_ovf to the out/wrap/ovf update.
- at_max and at_min follow out combinationally in the same cycle.
- Reset assertion clears outputs immediately. Deassertion is expected synchronised upstream; the first count can occur on the first rising edge after release.
- Reset mid-count or mid-load: the in-flight operation is discarded and out = MIN_VAL.
- Single clock domain; no combinational path from inputs to out, wrap or ovf.

## Configuration
- Macro: UPDOWN_COUNTER_SAT_EN.
- Defined: sat_mode is honoured as described in Operation.
- Undefined:
  - sat_mode is ignored and the counter always wraps.
  - The port remains present so instantiations do not change.
  - No saturation logic is synthesised.

## Test plan
All scenarios use WIDTH=4, MIN_VAL=2, MAX_VAL=12, STEP=3, and start from reset release unless stated.
- Reset release, en = 1, chnge = 1 for 3 edges → out = 2, 5, 8, 11; wrap = 0; ovf = 0; at_min = 1 only at 2.
- Load 11 then one up-count, sat_mode = 0 → out = 2, wrap = 1 for one cycle, ovf = 1 until clr_ovf. Same with sat_mode = 1 (macro defined) → out = 12, a second up-count keeps out = 12 with wrap = 1 again.
- Load 3, one down-count, sat_mode = 0 → out = 12, wrap pulse, ovf = 1. Load 15 → out = 12 (clamped), at_max = 1, wrap = 0.
- Boundary event and clr_ovf on the same edge → ovf = 1. Next edge clr_ovf = 1, en = 0 → ovf = 0, out holds.
- load = 1 and en = 1 together with load_val = 7 → out = 7 (load wins). Assert reset between edges mid-count → out = 2, wrap = 0, ovf = 0 immediately, before the next CLK edge.
- Macro undefined, sat_mode = 1, out = 11, up-count → out = 2 (wraps regardless of sat_mode).

Source files
------------

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with a configurable range and
//               step, count enable and synchronous load. At the range limits
//               it either wraps or saturates. It also provides terminal-count
//               flags, a one-cycle boundary pulse and a sticky overflow flag.
//               Saturation is only built when UPDOWN_COUNTER_SAT_EN is
//               defined. Otherwise the counter always wraps and sat_mode
//               is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] MIN_VAL = '0,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH:0]   STEP    = (WIDTH+1)'(1)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             en,
   input  logic             chnge,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] out,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap,
   output logic             ovf
);

   // Limits widened by one bit so that sums and thresholds cannot overflow.
   // MIN_VAL + STEP can never exceed 2**WIDTH, because STEP <= MAX_VAL-MIN_VAL+1.
   localparam logic [WIDTH:0] c_max_ext  = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] c_dn_floor = {1'b0, MIN_VAL} + STEP;

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH:0]   w_up_sum;
   logic             w_up_ok;
   logic             w_dn_ok;
   logic [WIDTH-1:0] w_dn_diff;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_evt;
   logic             w_ovf_nxt;
   logic             w_sat;

`ifdef UPDOWN_COUNTER_SAT_EN
   assign w_sat = sat_mode;
`else
   // The port is kept so that instantiations do not change. The value is
   // ignored, so the counter always wraps.
   logic w_unused_sat;
   assign w_unused_sat = sat_mode;
   assign w_sat        = 1'b0;
`endif

   // Range checks for one step in either direction, done in WIDTH+1 bits
   always_comb begin
      w_up_sum  = {1'b0, r_cnt} + STEP;
      w_up_ok   = (w_up_sum <= c_max_ext);
      w_dn_ok   = ({1'b0, r_cnt} >= c_dn_floor);
      // Only used when w_dn_ok holds. In that case STEP < 2**WIDTH.
      w_dn_diff = r_cnt - STEP[WIDTH-1:0];
   end

   // Clamp the load value into [MIN_VAL, MAX_VAL]
   always_comb begin
      w_load_clamped = load_val;
      if (load_val < MIN_VAL)
         w_load_clamped = MIN_VAL;
      else if (load_val > MAX_VAL)
         w_load_clamped = MAX_VAL;
   end

   // Next count and boundary event, with priority load > en > hold
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_evt     = 1'b0;
      if (load) begin
         w_cnt_nxt = w_load_clamped;
      end else if (en) begin
         if (chnge) begin
            if (w_up_ok) begin
               w_cnt_nxt = w_up_sum[WIDTH-1:0];
            end else begin
               w_evt     = 1'b1;
               w_cnt_nxt = w_sat ? MAX_VAL : MIN_VAL;
            end
         end else begin
            if (w_dn_ok) begin
               w_cnt_nxt = w_dn_diff;
            end else begin
               w_evt     = 1'b1;
               w_cnt_nxt = w_sat ? MIN_VAL : MAX_VAL;
            end
         end
      end
      // A set and a clear on the same edge leave the flag set
      w_ovf_nxt = w_evt | (r_ovf & ~clr_ovf);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_cnt  <= MIN_VAL;
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_wrap <= w_evt;
         r_ovf  <= w_ovf_nxt;
      end
   end

   assign out    = r_cnt;
   assign wrap   = r_wrap;
   assign ovf    = r_ovf;
   assign at_max = (r_cnt == MAX_VAL);
   assign at_min = (r_cnt == MIN_VAL);

endmodule
`default_nettype wire
